// File: rtl/cpu_debug_host_pkg.sv
// Shared types and constants for the CPU debug virtual-JTAG host driver.
package cpu_debug_host_pkg;

    localparam int unsigned DR_WIDTH = 38;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_E1DR = 3'd4,
        ST_RTI  = 3'd5,
        ST_RESP = 3'd6
    } state_t;

endpackage

// File: rtl/cpu_debug_host_tck_gen.sv
// Phase counter that turns clk into the virtual test clock. Each tck period
// is 2*TCK_HALF clk cycles, low phase first. Strobes are asserted during the
// clk cycle whose closing edge starts the high phase (tck_rise) or ends the
// period (tck_period_end).
module cpu_debug_host_tck_gen #(
    parameter int unsigned TCK_HALF = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic vji_tck,
    output logic tck_rise,
    output logic tck_period_end
);

    localparam int unsigned PERIOD = 2 * TCK_HALF;
    localparam int unsigned CW     = (PERIOD > 2) ? $clog2(PERIOD) : 1;

    localparam logic [CW-1:0] LAST_LOW = CW'(TCK_HALF - 1);
    localparam logic [CW-1:0] LAST     = CW'(PERIOD - 1);

    logic [CW-1:0] phase;

    assign tck_rise       = en && (phase == LAST_LOW);
    assign tck_period_end = en && (phase == LAST);

    // Advance the phase while enabled; park low with phase 0 otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase   <= '0;
            vji_tck <= 1'b0;
        end else if (!en || tck_period_end) begin
            phase   <= '0;
            vji_tck <= 1'b0;
        end else begin
            phase <= phase + 1'b1;
            if (tck_rise) begin
                vji_tck <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_debug_host_driver.sv
// Initiator-side sequencer for the CPU debug slave's virtual-JTAG port.
// Accepts an IR/data command, walks UIR, CDR, SDR x38, E1DR, RTI while
// shifting data out on vji_tdi and capturing vji_tdo, then returns the
// captured word on a response handshake.
module cpu_debug_host_driver
    import cpu_debug_host_pkg::*;
#(
    parameter int unsigned TCK_HALF   = 1,
    parameter int unsigned RTI_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [1:0]          vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_e1dr,
    output logic                vji_rti
);

    localparam int unsigned CNT_MAX = (RTI_CYCLES > DR_WIDTH) ? RTI_CYCLES : DR_WIDTH;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [DR_WIDTH-1:0] sr, sr_nx;
    logic [1:0]          ir_nx;
    logic                tdo_sample;
    logic                tck_en;
    logic                tck_rise;
    logic                tck_period_end;

    assign tck_en = (state != ST_IDLE) && (state != ST_RESP);

    cpu_debug_host_tck_gen #(
        .TCK_HALF(TCK_HALF)
    ) u_tck_gen (
        .clk           (clk),
        .reset         (reset),
        .en            (tck_en),
        .vji_tck       (vji_tck),
        .tck_rise      (tck_rise),
        .tck_period_end(tck_period_end)
    );

    // Next-state, period count and shift-register update.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sr_nx    = sr;
        ir_nx    = vji_ir_in;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    sr_nx    = cmd_data;
                    ir_nx    = cmd_ir;
                    state_nx = ST_UIR;
                end
            end
            ST_UIR: begin
                if (tck_period_end) begin
                    state_nx = ST_CDR;
                end
            end
            ST_CDR: begin
                if (tck_period_end) begin
                    state_nx = ST_SDR;
                    cnt_nx   = '0;
                end
            end
            ST_SDR: begin
                if (tck_period_end) begin
                    sr_nx = {tdo_sample, sr[DR_WIDTH-1:1]};
                    if (cnt == CNT_W'(DR_WIDTH - 1)) begin
                        state_nx = ST_E1DR;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            ST_E1DR: begin
                if (tck_period_end) begin
                    cnt_nx   = '0;
                    state_nx = (RTI_CYCLES == 0) ? ST_RESP : ST_RTI;
                end
            end
            ST_RTI: begin
                if (tck_period_end) begin
                    if (32'(cnt) + 32'd1 >= RTI_CYCLES) begin
                        state_nx = ST_RESP;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_valid && rsp_ready) begin
                    state_nx = ST_IDLE;
                    ir_nx    = 2'd0;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Capture vji_tdo on the edge that starts the tck high phase in SDR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tdo_sample <= 1'b0;
        end else if (tck_rise && (state == ST_SDR)) begin
            tdo_sample <= vji_tdo;
        end
    end

    // State registers plus outputs registered from the next-state decode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            sr        <= '0;
            vji_ir_in <= 2'd0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            vji_tdi   <= 1'b0;
            vji_uir   <= 1'b0;
            vji_cdr   <= 1'b0;
            vji_sdr   <= 1'b0;
            vji_e1dr  <= 1'b0;
            vji_rti   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            sr        <= sr_nx;
            vji_ir_in <= ir_nx;
            cmd_ready <= (state_nx == ST_IDLE);
            rsp_valid <= (state_nx == ST_RESP);
            rsp_data  <= (state_nx == ST_RESP) ? sr_nx : '0;
            vji_tdi   <= (state_nx == ST_SDR) ? sr_nx[0] : 1'b0;
            vji_uir   <= (state_nx == ST_UIR);
            vji_cdr   <= (state_nx == ST_CDR);
            vji_sdr   <= (state_nx == ST_SDR);
            vji_e1dr  <= (state_nx == ST_E1DR);
            vji_rti   <= (state_nx == ST_RTI);
        end
    end

endmodule

// File: tb/tb_cpu_debug_host_driver.sv
// Directed bench for cpu_debug_host_driver: default instance (TCK_HALF=1,
// RTI_CYCLES=2) plus a TCK_HALF=3, RTI_CYCLES=0 instance for sequence timing.
module tb_cpu_debug_host_driver;
    import cpu_debug_host_pkg::*;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_ir    = 2'd0;
    logic [37:0] cmd_data  = '0;
    logic        rsp_ready = 1'b1;
    logic [1:0]  tdo_mode  = 2'd0;

    logic        cmd_ready, rsp_valid, vji_tck, vji_tdi, vji_tdo;
    logic [37:0] rsp_data;
    logic [1:0]  vji_ir_in;
    logic        vji_uir, vji_cdr, vji_sdr, vji_e1dr, vji_rti;

    logic        cmd_valid2 = 1'b0;
    logic        cmd_ready2, rsp_valid2, vji_tck2, vji_tdi2, vji_tdo2;
    logic [37:0] rsp_data2;
    logic [1:0]  vji_ir_in2;
    logic        vji_uir2, vji_cdr2, vji_sdr2, vji_e1dr2, vji_rti2;

    // Slave model: 0 = loopback, 1 = tied high, 2 = tied low.
    assign vji_tdo  = (tdo_mode == 2'd0) ? vji_tdi : (tdo_mode == 2'd1);
    assign vji_tdo2 = vji_tdi2;

    always #5 clk = ~clk;

    cpu_debug_host_driver dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_data(rsp_data), .vji_tck(vji_tck),
        .vji_tdi(vji_tdi), .vji_tdo(vji_tdo), .vji_ir_in(vji_ir_in),
        .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr),
        .vji_e1dr(vji_e1dr), .vji_rti(vji_rti)
    );

    cpu_debug_host_driver #(
        .TCK_HALF(3),
        .RTI_CYCLES(0)
    ) dut_fast (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid2),
        .rsp_ready(1'b1), .rsp_data(rsp_data2), .vji_tck(vji_tck2),
        .vji_tdi(vji_tdi2), .vji_tdo(vji_tdo2), .vji_ir_in(vji_ir_in2),
        .vji_uir(vji_uir2), .vji_cdr(vji_cdr2), .vji_sdr(vji_sdr2),
        .vji_e1dr(vji_e1dr2), .vji_rti(vji_rti2)
    );

    function automatic logic [48:0] dut_outs();
        return {cmd_ready, rsp_valid, rsp_data, vji_tck, vji_tdi, vji_ir_in,
                vji_uir, vji_cdr, vji_sdr, vji_e1dr, vji_rti};
    endfunction

    // Offer a command on the default instance; returns at the first negedge
    // after the accepting clock edge with cmd_valid dropped.
    task automatic issue_cmd(input logic [1:0] ir, input logic [37:0] d, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        cmd_ir    = ir;
        cmd_data  = d;
        cmd_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Observe the default instance from negedge 1 after acceptance until
    // rsp_valid; lat is the negedge index at which rsp_valid is first seen.
    task automatic watch_rsp(input logic [1:0] exp_ir, output int lat, output bit ir_ok,
                             output logic [37:0] tdi_bits, output int n_uir, output int n_cdr,
                             output int n_sdr, output int n_e1dr, output int n_rti,
                             output int onehot_bad);
        int   bitn;
        logic prev_tck;
        lat = -1; ir_ok = 1'b1; tdi_bits = '0; onehot_bad = 0;
        n_uir = 0; n_cdr = 0; n_sdr = 0; n_e1dr = 0; n_rti = 0;
        bitn = 0; prev_tck = 1'b0;
        for (int n = 1; n <= 1000; n++) begin
            if (rsp_valid === 1'b1) begin
                lat = n;
                break;
            end
            if (vji_ir_in !== exp_ir) ir_ok = 1'b0;
            if ($countones({vji_uir, vji_cdr, vji_sdr, vji_e1dr, vji_rti}) != 1) onehot_bad++;
            if (vji_uir)  n_uir++;
            if (vji_cdr)  n_cdr++;
            if (vji_sdr)  n_sdr++;
            if (vji_e1dr) n_e1dr++;
            if (vji_rti)  n_rti++;
            if (vji_sdr && vji_tck && !prev_tck && bitn < 38) begin
                tdi_bits[bitn] = vji_tdi;
                bitn++;
            end
            prev_tck = vji_tck;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (dut_outs() !== 49'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", dut_outs());
        end
        reset = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_edge: got %b expected 0", cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || cmd_ready2 !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset: got %b/%b expected 1/1", cmd_ready, cmd_ready2);
        end
    endtask

    task automatic test_loopback();
        bit ok, ir_ok;
        int lat, nu, nc, ns, ne, nr, bad;
        logic [37:0] tb, d;
        d = 38'h12_3456_789A;
        tdo_mode = 2'd0;
        rsp_ready = 1'b1;
        issue_cmd(IR_BREAK, d, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL loop_accept: got 0 expected 1");
        end
        watch_rsp(IR_BREAK, lat, ir_ok, tb, nu, nc, ns, ne, nr, bad);
        checks++;
        if (lat != 87) begin
            failures++;
            $display("FAIL loop_latency: got %0d expected 87", lat);
        end
        checks++;
        if (rsp_data !== d) begin
            failures++;
            $display("FAIL loop_rsp_data: got %h expected %h", rsp_data, d);
        end
        checks++;
        if (!ir_ok || vji_ir_in !== IR_BREAK) begin
            failures++;
            $display("FAIL loop_ir_in: got %0d expected 2", vji_ir_in);
        end
        checks++;
        if (tb !== d) begin
            failures++;
            $display("FAIL loop_tdi_order: got %h expected %h", tb, d);
        end
        checks++;
        if (nu != 2 || nc != 2 || ns != 76 || ne != 2 || nr != 4 || bad != 0) begin
            failures++;
            $display("FAIL loop_states: got uir=%0d cdr=%0d sdr=%0d e1dr=%0d rti=%0d bad=%0d expected 2 2 76 2 4 0",
                     nu, nc, ns, ne, nr, bad);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || vji_ir_in !== 2'd0 || vji_tck !== 1'b0) begin
            failures++;
            $display("FAIL loop_idle: got ready=%b valid=%b ir=%0d tck=%b expected 1 0 0 0",
                     cmd_ready, rsp_valid, vji_ir_in, vji_tck);
        end
    endtask

    task automatic test_tdo_const();
        bit ok, ir_ok;
        int lat, nu, nc, ns, ne, nr, bad;
        logic [37:0] tb, d;
        d = 38'h25_A5A5_0F0F;
        tdo_mode = 2'd1;
        issue_cmd(IR_TRACEMEM, d, ok);
        watch_rsp(IR_TRACEMEM, lat, ir_ok, tb, nu, nc, ns, ne, nr, bad);
        checks++;
        if (!ok || lat != 87 || rsp_data !== 38'h3F_FFFF_FFFF) begin
            failures++;
            $display("FAIL tdo_ones: got lat=%0d data=%h expected 87 3fffffffff", lat, rsp_data);
        end
        checks++;
        if (tb !== d || !ir_ok) begin
            failures++;
            $display("FAIL tdo_ones_tdi: got %h ir_ok=%b expected %h ir_ok=1", tb, ir_ok, d);
        end
        d = 38'h3F_FFFF_FFFF;
        tdo_mode = 2'd2;
        issue_cmd(IR_TRACECTRL, d, ok);
        watch_rsp(IR_TRACECTRL, lat, ir_ok, tb, nu, nc, ns, ne, nr, bad);
        checks++;
        if (!ok || lat != 87 || rsp_data !== 38'h0) begin
            failures++;
            $display("FAIL tdo_zeros: got lat=%0d data=%h expected 87 0", lat, rsp_data);
        end
        checks++;
        if (tb !== d || !ir_ok) begin
            failures++;
            $display("FAIL tdo_zeros_tdi: got %h ir_ok=%b expected %h ir_ok=1", tb, ir_ok, d);
        end
        @(negedge clk);
        tdo_mode = 2'd0;
    endtask

    task automatic test_sequence_fast();
        bit ok;
        int lat, nu, nc, ns, ne, nr, bad;
        logic [37:0] d;
        d = 38'h0A_BCDE_F012;
        ok = 1'b0; lat = -1; nu = 0; nc = 0; ns = 0; ne = 0; nr = 0; bad = 0;
        @(negedge clk);
        cmd_ir = IR_TRACEMEM;
        cmd_data = d;
        cmd_valid2 = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (cmd_ready2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_valid2 = 1'b0;
        for (int n = 1; n <= 1000; n++) begin
            if (rsp_valid2 === 1'b1) begin
                lat = n;
                break;
            end
            if ($countones({vji_uir2, vji_cdr2, vji_sdr2, vji_e1dr2, vji_rti2}) != 1) bad++;
            if (vji_uir2)  nu++;
            if (vji_cdr2)  nc++;
            if (vji_sdr2)  ns++;
            if (vji_e1dr2) ne++;
            if (vji_rti2)  nr++;
            @(negedge clk);
        end
        checks++;
        if (!ok || nu != 6 || nc != 6 || ns != 228 || ne != 6 || bad != 0) begin
            failures++;
            $display("FAIL fast_states: got uir=%0d cdr=%0d sdr=%0d e1dr=%0d bad=%0d expected 6 6 228 6 0",
                     nu, nc, ns, ne, bad);
        end
        checks++;
        if (nr != 0) begin
            failures++;
            $display("FAIL fast_no_rti: got %0d expected 0", nr);
        end
        checks++;
        if (lat != 247) begin
            failures++;
            $display("FAIL fast_latency: got %0d expected 247", lat);
        end
        checks++;
        if (rsp_data2 !== d || vji_ir_in2 !== IR_TRACEMEM) begin
            failures++;
            $display("FAIL fast_rsp: got %h ir=%0d expected %h ir=1", rsp_data2, vji_ir_in2, d);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit ok, ir_ok;
        int lat, nu, nc, ns, ne, nr, bad, held_bad, after_bad;
        logic [37:0] tb, d;
        d = 38'h2C_0FFE_E123;
        held_bad = 0; after_bad = 0;
        rsp_ready = 1'b0;
        issue_cmd(IR_TRACEMEM, d, ok);
        watch_rsp(IR_TRACEMEM, lat, ir_ok, tb, nu, nc, ns, ne, nr, bad);
        checks++;
        if (!ok || lat != 87) begin
            failures++;
            $display("FAIL bp_latency: got %0d expected 87", lat);
        end
        cmd_valid = 1'b1;
        cmd_ir = IR_OCIMEM;
        cmd_data = 38'h01_1111_1111;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_data !== d || cmd_ready !== 1'b0 ||
                vji_uir !== 1'b0 || vji_ir_in !== IR_TRACEMEM) held_bad++;
        end
        checks++;
        if (held_bad != 0) begin
            failures++;
            $display("FAIL bp_hold: got %0d bad cycles expected 0 (data=%h)", held_bad, rsp_data);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || vji_ir_in !== 2'd0) begin
            failures++;
            $display("FAIL bp_release: got ready=%b valid=%b ir=%0d expected 1 0 0",
                     cmd_ready, rsp_valid, vji_ir_in);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (vji_uir !== 1'b0 || cmd_ready !== 1'b1) after_bad++;
        end
        checks++;
        if (after_bad != 0) begin
            failures++;
            $display("FAIL bp_no_accept: got %0d bad cycles expected 0", after_bad);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, ir_ok;
        int lat, nu, nc, ns, ne, nr, bad, stray;
        logic [37:0] tb, d;
        stray = 0;
        rsp_ready = 1'b1;
        issue_cmd(IR_BREAK, 38'h15_5555_AAAA, ok);
        repeat (38) @(negedge clk);
        checks++;
        if (!ok || vji_sdr !== 1'b1 || vji_tck !== 1'b0) begin
            failures++;
            $display("FAIL mid_in_sdr: got sdr=%b tck=%b expected 1 0", vji_sdr, vji_tck);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (dut_outs() !== 49'd0) begin
            failures++;
            $display("FAIL mid_async_reset: got %h expected 0", dut_outs());
        end
        repeat (3) @(negedge clk);
        checks++;
        if (dut_outs() !== 49'd0) begin
            failures++;
            $display("FAIL mid_reset_hold: got %h expected 0", dut_outs());
        end
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || vji_uir !== 1'b0 || cmd_ready !== 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL mid_no_response: got %0d bad cycles expected 0", stray);
        end
        d = 38'h30_DEAD_BEEF;
        issue_cmd(IR_OCIMEM, d, ok);
        watch_rsp(IR_OCIMEM, lat, ir_ok, tb, nu, nc, ns, ne, nr, bad);
        checks++;
        if (!ok || lat != 87 || rsp_data !== d || !ir_ok) begin
            failures++;
            $display("FAIL mid_recover: got lat=%0d data=%h expected 87 %h", lat, rsp_data, d);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok, ir_ok;
        int lat, nu, nc, ns, ne, nr, bad, gap;
        logic [37:0] tb, da, db;
        da = 38'h01_2345_6789;
        db = 38'h3E_DCBA_9876;
        ok = 1'b0; gap = -1;
        rsp_ready = 1'b1;
        tdo_mode = 2'd0;
        @(negedge clk);
        cmd_ir = IR_OCIMEM;
        cmd_data = da;
        cmd_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cmd_ir = IR_TRACEMEM;
        cmd_data = db;
        watch_rsp(IR_OCIMEM, lat, ir_ok, tb, nu, nc, ns, ne, nr, bad);
        checks++;
        if (!ok || lat != 87 || rsp_data !== da) begin
            failures++;
            $display("FAIL b2b_first: got lat=%0d data=%h expected 87 %h", lat, rsp_data, da);
        end
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                gap = n;
                break;
            end
        end
        checks++;
        if (gap != 1) begin
            failures++;
            $display("FAIL b2b_gap: got %0d expected 1", gap);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        watch_rsp(IR_TRACEMEM, lat, ir_ok, tb, nu, nc, ns, ne, nr, bad);
        checks++;
        if (lat != 87 || rsp_data !== db || !ir_ok) begin
            failures++;
            $display("FAIL b2b_second: got lat=%0d data=%h expected 87 %h", lat, rsp_data, db);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_tdo_const();
        test_sequence_fast();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
